arbitro_escrita_banco: RTL

//  Shares the single write port of banco_de_registradores among N_REQ writeback sources (ALU, load unit, I/O).

---
 rtl/arbitro_escrita_banco.sv | 96 +++++++++
 1 files changed

// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco
//   Round-robin arbiter that lets N_REQ writeback sources share the single
//   write port of banco_de_registradores. The winner's write is registered
//   and presented on regWrite/RD/dadosEscrita for one cycle. A pending-write
//   vector flags registers whose newest value has not reached the bank yet.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   req           per-requester write request
//   req_rd        destination of requester i at [i*W_END +: W_END]
//   req_dado      data of requester i at [i*W_DADO +: W_DADO]
//   bloqueio      pipeline freeze: no grants while high
//   grant         one-hot combinational grant (zero when idle/blocked/reset)
//   regWrite      registered write enable to the bank
//   RD            registered destination register
//   dadosEscrita  registered write data
//   pendentes     bit r set: a write to register r has not landed yet
module arbitro_escrita_banco #(
  parameter int N_REQ  = 3,
  parameter int W_DADO = 32,
  parameter int W_END  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*W_END-1:0]    req_rd,
  input  logic [N_REQ*W_DADO-1:0]   req_dado,
  input  logic                      bloqueio,
  output logic [N_REQ-1:0]          grant,
  output logic                      regWrite,
  output logic [W_END-1:0]          RD,
  output logic [W_DADO-1:0]         dadosEscrita,
  output logic [(2**W_END)-1:0]     pendentes
);

  localparam int W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [W_PTR-1:0]  ptr;
  logic [W_PTR-1:0]  ptrProx;
  logic              aceito;
  logic [W_END-1:0]  rdVenc;
  logic [W_DADO-1:0] dadoVenc;

  // Grant is only ever raised on a requesting line, so a non-zero grant is
  // itself the acceptance for this edge.
  always_comb begin
    int idx;
    grant    = '0;
    aceito   = 1'b0;
    ptrProx  = ptr;
    rdVenc   = '0;
    dadoVenc = '0;
    idx      = 0;
    if (!reset && !bloqueio) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!aceito && req[idx]) begin
          aceito     = 1'b1;
          grant[idx] = 1'b1;
          rdVenc     = req_rd[idx*W_END +: W_END];
          dadoVenc   = req_dado[idx*W_DADO +: W_DADO];
          ptrProx    = (idx == N_REQ - 1) ? '0 : W_PTR'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      regWrite     <= 1'b0;
      RD           <= '0;
      dadosEscrita <= '0;
    end else begin
      ptr <= ptrProx;
      // Writes to $zero are consumed but never reach the bank.
      regWrite <= aceito && (rdVenc != '0);
      if (aceito) begin
        RD           <= rdVenc;
        dadosEscrita <= dadoVenc;
      end
    end
  end

  always_comb begin
    pendentes = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) pendentes[req_rd[i*W_END +: W_END]] = 1'b1;
    end
    if (regWrite) pendentes[RD] = 1'b1;
    pendentes[0] = 1'b0;
  end

endmodule
